// File: rtl/shift_reg_stream_pkg.sv
// shift_reg_stream_pkg: opcode and FSM state types plus the
// default width of the remaining-step counter.
package shift_reg_stream_pkg;

  localparam int CNT_WIDTH = 8;

  typedef enum logic [2:0] {
    OP_LOAD = 3'd0,
    OP_SHL  = 3'd1,
    OP_SHR  = 3'd2,
    OP_ROL  = 3'd3,
    OP_ROR  = 3'd4
  } op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/shift_reg_stream_dp.sv
// shift_reg_stream_dp: DEPTH x ELEM_WIDTH register array.
// Ports: load/pi parallel load, step/dir/rot/si one-element move,
// po contents, so exit element for dir (0=left, 1=right).
// Rotate muxing exists only with SHIFT_REG_STREAM_ROTATE_EN.
module shift_reg_stream_dp #(
  parameter int ELEM_WIDTH = 4,
  parameter int DEPTH      = 8
) (
  input  logic                        clk_i,
  input  logic                        arst_n,
  input  logic                        load,
  input  logic                        step,
  input  logic                        dir,
  input  logic                        rot,
  input  logic [ELEM_WIDTH-1:0]       si,
  input  logic [DEPTH*ELEM_WIDTH-1:0] pi,
  output logic [DEPTH*ELEM_WIDTH-1:0] po,
  output logic [ELEM_WIDTH-1:0]       so
);

  localparam int W = ELEM_WIDTH;
  localparam int N = DEPTH * ELEM_WIDTH;

  logic [N-1:0] po_q;
  logic [N-1:0] shl_v;
  logic [N-1:0] shr_v;
  logic [W-1:0] hi_e;
  logic [W-1:0] lo_e;
  logic [W-1:0] in_e;

  assign hi_e = po_q[N-1 -: W];
  assign lo_e = po_q[W-1:0];

`ifdef SHIFT_REG_STREAM_ROTATE_EN
  // A rotate feeds the element leaving one end back in the other.
  assign in_e = rot ? (dir ? lo_e : hi_e) : si;
`else
  logic unused_rot;
  assign unused_rot = rot;
  assign in_e       = si;
`endif

  assign shl_v = {po_q[N-W-1:0], in_e};
  assign shr_v = {in_e, po_q[N-1:W]};

  always_ff @(posedge clk_i) begin
    if (!arst_n) begin
      po_q <= '0;
    end else if (load) begin
      po_q <= pi;
    end else if (step) begin
      po_q <= dir ? shr_v : shl_v;
    end
  end

  assign po = po_q;
  assign so = dir ? lo_e : hi_e;

endmodule

// File: rtl/shift_reg_stream.sv
// shift_reg_stream: command FSM, step counter and stream handshake
// around the register array. Ports: cmd_* command, pi/po parallel,
// si*/so* element streams, busy/done/err status.
// Define SHIFT_REG_STREAM_ROTATE_EN to enable OP_ROL/OP_ROR.
module shift_reg_stream
  import shift_reg_stream_pkg::*;
#(
  parameter int ELEM_WIDTH = 4,
  parameter int DEPTH      = 8,
  parameter int CNT_WIDTH  = shift_reg_stream_pkg::CNT_WIDTH
) (
  input  logic                        clk_i,
  input  logic                        arst_n,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  op_e                         cmd_op,
  input  logic [CNT_WIDTH-1:0]        cmd_cnt,
  input  logic [DEPTH*ELEM_WIDTH-1:0] pi,
  output logic [DEPTH*ELEM_WIDTH-1:0] po,
  input  logic [ELEM_WIDTH-1:0]       si,
  input  logic                        si_valid,
  output logic                        si_ready,
  output logic [ELEM_WIDTH-1:0]       so,
  output logic                        so_valid,
  input  logic                        so_ready,
  output logic                        busy,
  output logic                        done,
  output logic                        err
);

  state_e               state_q;
  state_e               state_d;
  logic [CNT_WIDTH-1:0] rem_q;
  logic                 dir_q;
  logic                 rot_q;
  logic                 done_q;
  logic                 err_q;

  logic accept;
  logic legal;
  logic mover;
  logic cmd_dir;
  logic cmd_rot;
  logic cnt_zero;
  logic step;
  logic last;
  logic load;

  assign accept   = cmd_valid && (state_q == ST_IDLE);
  assign cnt_zero = (cmd_cnt == '0);
  assign cmd_dir  = (cmd_op == OP_SHR) || (cmd_op == OP_ROR);
  assign cmd_rot  = (cmd_op == OP_ROL) || (cmd_op == OP_ROR);
  assign load     = accept && (cmd_op == OP_LOAD);

  always_comb begin
    legal = 1'b0;
    mover = 1'b0;
    unique case (cmd_op)
      OP_LOAD: legal = 1'b1;
      OP_SHL, OP_SHR: begin
        legal = 1'b1;
        mover = 1'b1;
      end
`ifdef SHIFT_REG_STREAM_ROTATE_EN
      OP_ROL, OP_ROR: begin
        legal = 1'b1;
        mover = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  // Rotates never wait on the streams; shifts need both sides.
  assign step = (state_q == ST_RUN)
             && (rot_q || (si_valid && so_ready));
  assign last = step && (rem_q == CNT_WIDTH'(1));

  always_ff @(posedge clk_i) begin
    if (!arst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept && legal && mover && !cnt_zero) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (last) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state_q == ST_IDLE);
    busy      = (state_q == ST_RUN);
    si_ready  = busy && !rot_q && so_ready;
    so_valid  = busy && !rot_q && si_valid;
  end

  always_ff @(posedge clk_i) begin
    if (!arst_n) begin
      rem_q  <= '0;
      dir_q  <= 1'b0;
      rot_q  <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      done_q <= (accept && legal && (!mover || cnt_zero)) || last;
      err_q  <= accept && !legal;
      if (accept && legal && mover) begin
        rem_q <= cmd_cnt;
        dir_q <= cmd_dir;
        rot_q <= cmd_rot;
      end else if (step) begin
        rem_q <= rem_q - CNT_WIDTH'(1);
      end
    end
  end

  assign done = done_q;
  assign err  = err_q;

  shift_reg_stream_dp #(
    .ELEM_WIDTH(ELEM_WIDTH),
    .DEPTH     (DEPTH)
  ) u_dp (
    .clk_i (clk_i),
    .arst_n(arst_n),
    .load  (load),
    .step  (step),
    .dir   (dir_q),
    .rot   (rot_q),
    .si    (si),
    .pi    (pi),
    .po    (po),
    .so    (so)
  );

endmodule

// File: tb/tb_shift_reg_stream.sv
// tb_shift_reg_stream: randomized scenarios against a queue-based
// model of the contents and the serial element streams.
module tb_shift_reg_stream;
  import shift_reg_stream_pkg::*;

  localparam int W  = 4;
  localparam int D  = 8;
  localparam int CW = 8;
  localparam int N  = D * W;

  logic          clk_i = 1'b0;
  logic          arst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  op_e           cmd_op;
  logic [CW-1:0] cmd_cnt;
  logic [N-1:0]  pi;
  logic [N-1:0]  po;
  logic [W-1:0]  si;
  logic          si_valid;
  logic          si_ready;
  logic [W-1:0]  so;
  logic          so_valid;
  logic          so_ready;
  logic          busy;
  logic          done;
  logic          err;

  int tests = 0;
  int fails = 0;

  logic [N-1:0] mdl;
  logic         mdl_right;

  always #5 clk_i = ~clk_i;

  shift_reg_stream #(
    .ELEM_WIDTH(W),
    .DEPTH     (D),
    .CNT_WIDTH (CW)
  ) dut (
    .clk_i    (clk_i),
    .arst_n   (arst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .cmd_cnt  (cmd_cnt),
    .pi       (pi),
    .po       (po),
    .si       (si),
    .si_valid (si_valid),
    .si_ready (si_ready),
    .so       (so),
    .so_valid (so_valid),
    .so_ready (so_ready),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  function automatic logic [W-1:0] elem(logic [N-1:0] v, int i);
    return v[i*W +: W];
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic issue(op_e op, int cnt, logic [N-1:0] p);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_cnt   = CW'(cnt);
    pi        = p;
    tick();
    cmd_valid = 1'b0;
    pi        = {$urandom, $urandom};
  endtask

  task automatic test_reset();
    arst_n   = 1'b0;
    si_valid = 1'b1;
    so_ready = 1'b1;
    tick();
    tick();
    arst_n = 1'b1;
    #1;
    tests++;
    if (po !== '0) begin
      fails++; $display("FAIL reset_po: got %h want 0", po);
    end
    tests++;
    if ({cmd_ready, busy, done, err} !== 4'b1000) begin
      fails++; $display("FAIL reset_status: got %b want 1000", {cmd_ready, busy, done, err});
    end
    tests++;
    if ({si_ready, so_valid, so} !== 6'b0) begin
      fails++; $display("FAIL reset_stream: got %b want 0", {si_ready, so_valid, so});
    end
    si_valid  = 1'b0;
    so_ready  = 1'b0;
    mdl       = '0;
    mdl_right = 1'b0;
  endtask

  task automatic test_load(logic [N-1:0] p);
    issue(OP_LOAD, $urandom_range(0, 255), p);
    tests++;
    if (po !== p) begin
      fails++; $display("FAIL load_po: got %h want %h", po, p);
    end
    tests++;
    if ({done, err, busy, cmd_ready} !== 4'b1001) begin
      fails++; $display("FAIL load_done: got %b want 1001", {done, err, busy, cmd_ready});
    end
    mdl = p;
    tick();
    tests++;
    if ({done, busy} !== 2'b00) begin
      fails++; $display("FAIL load_after: got %b want 00", {done, busy});
    end
  endtask

  // mode 0: no stalls, 1: random stalls, 2: so_ready low 2 cycles
  task automatic test_shift(op_e op, int n, int mode);
    logic [W-1:0] seq[$];
    logic [N-1:0] exp_v;
    logic [N-1:0] hold;
    logic         right;
    logic         fire;
    int           k;
    int           cyc;
    right = (op == OP_SHR);
    for (int i = 0; i < D; i++)
      seq.push_back(right ? elem(mdl, i) : elem(mdl, D-1-i));
    for (int i = 0; i < n; i++)
      seq.push_back(W'($urandom));
    issue(op, n, {$urandom, $urandom});
    k   = 0;
    cyc = 0;
    while (k < n && cyc < 400) begin
      unique case (mode)
        0: begin si_valid = 1'b1; so_ready = 1'b1; end
        1: begin
          si_valid  = ($urandom_range(0, 3) != 0);
          so_ready  = ($urandom_range(0, 3) != 0);
          cmd_valid = $urandom_range(0, 1);
          cmd_op    = OP_LOAD;
          pi        = {$urandom, $urandom};
        end
        default: begin
          si_valid = 1'b1;
          so_ready = !(cyc == 1 || cyc == 2);
        end
      endcase
      si = seq[D+k];
      #1;
      fire = si_valid && so_ready;
      hold = po;
      tests++;
      if ({busy, cmd_ready, si_ready, so_valid} !== {2'b10, so_ready, si_valid}) begin
        fails++; $display("FAIL shift_hs: got %b want %b", {busy, cmd_ready, si_ready, so_valid}, {2'b10, so_ready, si_valid});
      end
      if (fire) begin
        tests++;
        if (so !== seq[k]) begin
          fails++; $display("FAIL shift_so: step %0d got %h want %h", k, so, seq[k]);
        end
        k++;
      end
      tick();
      cyc++;
      if (!fire) begin
        tests++;
        if (po !== hold) begin
          fails++; $display("FAIL shift_stall: got %h want %h", po, hold);
        end
      end
    end
    cmd_valid = 1'b0;
    si_valid  = 1'b0;
    so_ready  = 1'b0;
    tests++;
    if (k != n) begin
      fails++; $display("FAIL shift_timeout: got %0d steps want %0d", k, n);
    end
    for (int j = 0; j < D; j++)
      exp_v[(right ? j : D-1-j)*W +: W] = seq[n+j];
    tests++;
    if (po !== exp_v) begin
      fails++; $display("FAIL shift_po: got %h want %h", po, exp_v);
    end
    tests++;
    if ({done, err, busy, cmd_ready} !== 4'b1001) begin
      fails++; $display("FAIL shift_done: got %b want 1001", {done, err, busy, cmd_ready});
    end
    tests++;
    if (so !== (right ? elem(exp_v, 0) : elem(exp_v, D-1))) begin
      fails++; $display("FAIL shift_idle_so: got %h want %h", so, right ? elem(exp_v, 0) : elem(exp_v, D-1));
    end
    if (mode != 1) begin
      tests++;
      if (cyc != n + (mode == 2 ? 2 : 0)) begin
        fails++; $display("FAIL shift_cycles: got %0d want %0d", cyc, n + (mode == 2 ? 2 : 0));
      end
    end
    mdl       = exp_v;
    mdl_right = right;
  endtask

  task automatic test_rotate(op_e op, int n);
`ifdef SHIFT_REG_STREAM_ROTATE_EN
    logic [N-1:0] exp_v;
    int           sh;
    int           cyc;
    sh = n % D;
    for (int j = 0; j < D; j++)
      exp_v[j*W +: W] = (op == OP_ROL) ? elem(mdl, (j - sh + D) % D)
                                       : elem(mdl, (j + sh) % D);
    issue(op, n, {$urandom, $urandom});
    cyc = 0;
    while (busy === 1'b1 && cyc < 300) begin
      si_valid = $urandom_range(0, 1);
      so_ready = $urandom_range(0, 1);
      #1;
      tests++;
      if ({si_ready, so_valid} !== 2'b00) begin
        fails++; $display("FAIL rot_stream: got %b want 00", {si_ready, so_valid});
      end
      tick();
      cyc++;
    end
    si_valid = 1'b0;
    so_ready = 1'b0;
    tests++;
    if (cyc != n) begin
      fails++; $display("FAIL rot_cycles: got %0d want %0d", cyc, n);
    end
    tests++;
    if (po !== exp_v) begin
      fails++; $display("FAIL rot_po: got %h want %h", po, exp_v);
    end
    tests++;
    if ({done, err} !== 2'b10) begin
      fails++; $display("FAIL rot_done: got %b want 10", {done, err});
    end
    mdl       = exp_v;
    mdl_right = (op == OP_ROR);
`else
    issue(op, n, {$urandom, $urandom});
    tests++;
    if ({err, done, busy} !== 3'b100) begin
      fails++; $display("FAIL rot_err: got %b want 100", {err, done, busy});
    end
    tests++;
    if (po !== mdl) begin
      fails++; $display("FAIL rot_po_kept: got %h want %h", po, mdl);
    end
    tick();
    tests++;
    if (err !== 1'b0) begin
      fails++; $display("FAIL rot_err_pulse: got %b want 0", err);
    end
`endif
  endtask

  task automatic test_zero_illegal();
    si_valid = 1'b1;
    so_ready = 1'b1;
    issue(OP_SHL, 0, {$urandom, $urandom});
    tests++;
    if ({done, err, busy, so_valid} !== 4'b1000) begin
      fails++; $display("FAIL zero_cnt: got %b want 1000", {done, err, busy, so_valid});
    end
    tests++;
    if (po !== mdl) begin
      fails++; $display("FAIL zero_po: got %h want %h", po, mdl);
    end
    issue(op_e'(3'd6), $urandom_range(0, 255), {$urandom, $urandom});
    tests++;
    if ({err, done, busy} !== 3'b100) begin
      fails++; $display("FAIL illegal_err: got %b want 100", {err, done, busy});
    end
    tests++;
    if (po !== mdl) begin
      fails++; $display("FAIL illegal_po: got %h want %h", po, mdl);
    end
    si_valid = 1'b0;
    so_ready = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] p;
    test_load({$urandom, $urandom});
    test_shift(OP_SHL, 4, 0);
    p = {$urandom, $urandom};
    issue(OP_LOAD, 0, p);
    tests++;
    if ({po, done} !== {p, 1'b1}) begin
      fails++; $display("FAIL b2b_load: got %h/%b want %h/1", po, done, p);
    end
    mdl = p;
    test_shift(OP_SHR, 3, 0);
  endtask

  task automatic test_reset_mid();
    issue(OP_SHL, 5, {$urandom, $urandom});
    si_valid = 1'b1;
    so_ready = 1'b1;
    si       = W'($urandom);
    tick();
    arst_n = 1'b0;
    tick();
    arst_n = 1'b1;
    tests++;
    if ({po, busy, cmd_ready, done, so_valid} !== {{N{1'b0}}, 4'b0100}) begin
      fails++; $display("FAIL rst_mid: got %h %b want 0 0100", po, {busy, cmd_ready, done, so_valid});
    end
    tick();
    tests++;
    if ({done, busy} !== 2'b00) begin
      fails++; $display("FAIL rst_mid_done: got %b want 00", {done, busy});
    end
    si_valid  = 1'b0;
    so_ready  = 1'b0;
    mdl       = '0;
    mdl_right = 1'b0;
  endtask

  initial begin
    cmd_op   = OP_LOAD;
    cmd_cnt  = '0;
    pi       = '0;
    si       = '0;
    si_valid = 1'b0;
    so_ready = 1'b0;
    test_reset();
    test_load(32'h76543210);
    test_shift(OP_SHL, 3, 0);
    test_load(32'h76543210);
    test_shift(OP_SHR, 2, 2);
    test_load(32'h76543210);
    test_rotate(OP_ROL, 10);
    test_zero_illegal();
    for (int i = 0; i < 6; i++) begin
      test_load({$urandom, $urandom});
      test_shift(($urandom_range(0, 1) != 0) ? OP_SHR : OP_SHL,
                 $urandom_range(1, 12), 1);
      test_rotate(($urandom_range(0, 1) != 0) ? OP_ROR : OP_ROL,
                  $urandom_range(1, 20));
    end
    test_back_to_back();
    test_reset_mid();
    test_load({$urandom, $urandom});
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/shift_reg_stream.md
# shift_reg_stream

Command-driven, parametrised shift register with streaming serial ports. It parallel-loads, shifts left or right, or rotates its DEPTH×ELEM_WIDTH contents by a programmable element count. Shifts run one element per cycle under valid/ready flow control on the serial input and output. It sits between a parallel producer or consumer and a serial element stream, and acts as a serializer, deserializer or reorder buffer.

## Interface
- ELEM_WIDTH, 4, bits per element
- DEPTH, 8, number of elements (≥2)
- CNT_WIDTH, 8, width of the step-count field
- clk_i  input  1  clock
- arst_n  input  1  active-low reset; one clock, reset synchronous and active-low (sampled on rising clk_i only)
- cmd_valid  input  1  command offered
- cmd_ready  output  1  high in IDLE
- cmd_op  input  3  opcode (package enum)
- cmd_cnt  input  CNT_WIDTH  elements to shift/rotate
- pi  input  DEPTH×ELEM_WIDTH  parallel load data
- po  output  DEPTH×ELEM_WIDTH  register contents
- si  input  ELEM_WIDTH  serial element in; si_valid input 1; si_ready output 1
- so  output  ELEM_WIDTH  serial element out; so_valid output 1; so_ready input 1
- busy  output  1  state == RUN
- done  output  1  one-cycle completion pulse
- err  output  1  one-cycle pulse: illegal or disabled opcode

## Operation
- Opcodes: OP_LOAD=0, OP_SHL=1, OP_SHR=2, OP_ROL=3, OP_ROR=4. Codes 5–7 are illegal.
- FSM states: IDLE and RUN.
  - IDLE: cmd_ready=1. A command is accepted when cmd_valid && cmd_ready, and the op and count are latched.
  - OP_LOAD: po<=pi at the acceptance edge. Stay in IDLE. done=1 the next cycle.
  - cmd_cnt=0 with any legal op: contents unchanged, stay in IDLE, done=1 the next cycle.
  - Illegal op: contents unchanged, stay in IDLE, err=1 the next cycle, no done.
  - Shift/rotate with cnt≥1: go to RUN with remaining=cmd_cnt.
- RUN: one "step" moves exactly one element. remaining decrements per step. When a step takes remaining from 1 to 0, the FSM returns to IDLE and done=1 the next cycle.
- SHL step: po[0]<=si, po[i]<=po[i-1]. so=po[DEPTH-1].
- SHR step: po[DEPTH-1]<=si, po[i-1]<=po[i]. so=po[0].
- ROL step: po[0]<=po[DEPTH-1], rest as SHL. ROR step: the mirror of ROL.
- Shift handshake: a step fires when si_valid && so_ready.
  - so_valid = RUN && shift op && si_valid.
  - si_ready = RUN && shift op && so_ready.
  - Both transfers complete in the same cycle.
- Rotate steps fire every RUN cycle. si_ready=0 and so_valid=0 throughout.
- Counts above DEPTH are legal. Shifts stream straight through. Rotations wrap modulo DEPTH.
- Outside RUN-shift: si_ready=0, so_valid=0. so still shows the exit element of the last op direction (reset direction: SHL).

## Timing
- Reset values: po=0, cmd_ready=1 (IDLE), busy=0, done=0, err=0, si_ready=0, so_valid=0, so=0.
- Reset asserted mid-RUN aborts the operation at that edge. No done is issued.
- LOAD latency: 1 cycle to po. done follows in the cycle after the load edge.
- Shift/rotate of N with no stalls: N RUN cycles, then done in the next cycle.
- The cycle carrying done has cmd_ready=1, so back-to-back commands are allowed.
- A stall (si_valid=0 or so_ready=0) freezes po and remaining. There is no timeout.
- cmd_valid during RUN is ignored (cmd_ready=0).
- done and err are never asserted together.

## Configuration
- SHIFT_REG_STREAM_ROTATE_EN defined: OP_ROL and OP_ROR are implemented as specified.
- Not defined: OP_ROL and OP_ROR are treated as illegal (err pulse, contents unchanged, no RUN). The rotate datapath muxing is removed.

## Structure
- Package shift_reg_stream_pkg holds the opcode enum type (3 bits), the FSM state enum, and the localparam for the remaining-counter width (CNT_WIDTH).
- One sub-module, shift_reg_stream_dp: the register array.
  - Inputs: load, step, dir, rot, si.
  - Outputs: po, so.
- The top holds the FSM, the counter and the handshake logic.

## Test plan
- All tests use DEPTH=8 and ELEM_WIDTH=4. po is written as a hex string of elements 7..0.
- LOAD with pi=0x76543210 → po=0x76543210 one cycle later, done pulse the following cycle, busy never high.
- Then SHL cnt=3, si=A,B,C, so_ready=1 → so sequence 7,6,5, po=0x43210ABC, done one cycle after the third step.
- SHR cnt=2 from 0x76543210, with so_ready low for 2 cycles between steps → no step while stalled, so sequence 0,1, po=0xED765432 for si=D,E, total 4 RUN cycles.
- ROL cnt=10 from 0x76543210 with the macro defined → po=0x54321076 after 10 cycles, si_ready and so_valid stay 0. Same command with the macro undefined → err pulse, po unchanged.
- cmd_cnt=0 with SHL, then op=6 → done pulse with no so_valid, then err pulse with po unchanged.
- Reset asserted on the 2nd cycle of SHL cnt=5 → po=0, IDLE, no done. The next LOAD works normally.
